// File: rtl/alu_muldiv_if.sv
// Handshake and result bundle for the ALU / multiply / divide unit.
interface alu_muldiv_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [4:0]       opALU;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] F;
   logic [WIDTH-1:0] HI;
   logic             Z;
   logic             CO;
   logic             OV;

   modport master (
      output start, opALU, A, B,
      input  busy, done, F, HI, Z, CO, OV
   );

   modport slave (
      input  start, opALU, A, B,
      output busy, done, F, HI, Z, CO, OV
   );
endinterface

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arithmetic/compare ops plus an iterative
// unsigned shift-add multiplier and restoring divider sharing one datapath.
module alu_muldiv #(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst,
   alu_muldiv_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [4:0] OP_MULU = 5'b11000;
   localparam logic [4:0] OP_DIVU = 5'b11001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             isMulReg;
   // hiReg/loReg: accumulator + multiplier for MULU, remainder + quotient for DIVU
   logic [WIDTH-1:0] hiReg;
   logic [WIDTH-1:0] loReg;
   // multiplicand (MULU) or divisor (DIVU)
   logic [WIDTH-1:0] opndReg;

   logic             isMul, isDiv, isRsv;
   logic [WIDTH-1:0] opA, opB, aluF;
   logic             cin, aluCO, aluOV, arithCO, arithOV;
   logic [WIDTH:0]   sumFull;

   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift;
   logic             divFits;
   logic [WIDTH-1:0] divDiff;
   logic [WIDTH-1:0] stepHi, stepLo;

   // Opcode class decode for the request presented on the bus.
   always_comb begin
      isMul = (bus.opALU == OP_MULU);
      isDiv = (bus.opALU == OP_DIVU);
      isRsv = (bus.opALU[4:1] == 4'b1101);
   end

   // Single-cycle result from the bit-field decoded opcode.
   always_comb begin
      opA     = bus.opALU[3] ? ~bus.A : bus.A;
      opB     = bus.opALU[2] ? ~bus.B : bus.B;
      cin     = bus.opALU[2];
      sumFull = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, cin};
      arithCO = sumFull[WIDTH];
      // carry into the MSB recovered from the MSB sum bit and its operand bits
      arithOV = (sumFull[WIDTH-1] ^ opA[WIDTH-1] ^ opB[WIDTH-1]) ^ sumFull[WIDTH];
      aluF    = '0;
      aluCO   = 1'b0;
      aluOV   = 1'b0;
      if (!isRsv) begin
         case (bus.opALU[1:0])
            2'b00: aluF = opA & opB;
            2'b01: aluF = opA | opB;
            2'b10: begin
               aluF  = sumFull[WIDTH-1:0];
               aluCO = arithCO;
               aluOV = arithOV;
            end
            default: begin
               aluF  = {{(WIDTH-1){1'b0}},
                        bus.opALU[4] ? ~arithCO : (arithOV ^ sumFull[WIDTH-1])};
               aluCO = arithCO;
               aluOV = arithOV;
            end
         endcase
      end
   end

   // One multiply or divide iteration computed from the working registers.
   always_comb begin
      mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, opndReg} : {(WIDTH+1){1'b0}});
      divShift = {hiReg, loReg[WIDTH-1]};
      divFits  = (divShift >= {1'b0, opndReg});
      // remainder stays below the divisor, so modulo-2^WIDTH subtraction is exact
      divDiff  = divShift[WIDTH-1:0] - opndReg;
      if (isMulReg) begin
         stepHi = mulSum[WIDTH:1];
         stepLo = {mulSum[0], loReg[WIDTH-1:1]};
      end else begin
         stepHi = divFits ? divDiff : divShift[WIDTH-1:0];
         stepLo = {loReg[WIDTH-2:0], divFits};
      end
   end

   // Control FSM with registered outputs; results load only on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         isMulReg <= 1'b0;
         hiReg    <= '0;
         loReg    <= '0;
         opndReg  <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.F    <= '0;
         bus.HI   <= '0;
         bus.Z    <= 1'b1;
         bus.CO   <= 1'b0;
         bus.OV   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               if (bus.start) begin
                  if (isMul || isDiv) begin
                     state    <= RUN;
                     bus.busy <= 1'b1;
                     count    <= CNT_W'(WIDTH - 1);
                     isMulReg <= isMul;
                     hiReg    <= '0;
                     loReg    <= isMul ? bus.B : bus.A;
                     opndReg  <= isMul ? bus.A : bus.B;
                  end else begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                     bus.F    <= aluF;
                     bus.HI   <= '0;
                     bus.Z    <= (aluF == '0);
                     bus.CO   <= aluCO;
                     bus.OV   <= aluOV;
                  end
               end
            end
            RUN: begin
               hiReg <= stepHi;
               loReg <= stepLo;
               if (count == '0) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.F    <= stepLo;
                  bus.HI   <= stepHi;
                  bus.Z    <= (stepLo == '0);
                  bus.CO   <= 1'b0;
                  bus.OV   <= isMulReg ? (stepHi != '0) : (opndReg == '0);
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized bench for alu_muldiv against an arithmetic reference model,
// with directed literal cases pinning the model.
module tb_alu_muldiv;

   localparam int W = 8;
   localparam int unsigned FULL = 1 << W;
   localparam int unsigned MASK = FULL - 1;
   localparam int unsigned HALF = FULL / 2;

   localparam logic [4:0] OP_AND  = 5'b00000;
   localparam logic [4:0] OP_OR   = 5'b00001;
   localparam logic [4:0] OP_ADD  = 5'b00010;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_NOR  = 5'b01100;
   localparam logic [4:0] OP_SLT  = 5'b00111;
   localparam logic [4:0] OP_SLTU = 5'b10111;
   localparam logic [4:0] OP_MULU = 5'b11000;
   localparam logic [4:0] OP_DIVU = 5'b11001;
   localparam logic [4:0] OP_RSV0 = 5'b11010;
   localparam logic [4:0] OP_RSV1 = 5'b11011;

   typedef struct packed {
      logic [W-1:0] f;
      logic [W-1:0] hi;
      logic         z;
      logic         co;
      logic         ov;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_muldiv_if #(.WIDTH(W)) bus ();

   alu_muldiv #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chkEn = 1'b0;

   // model state
   bit   pending = 1'b0;
   bit   justDone = 1'b0;
   int   remain = 0;
   logic mBusy = 1'b0;
   logic mDone = 1'b0;
   res_t mRes = '0;
   res_t pendRes = '0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result from plain integer arithmetic.
   function automatic res_t refModel(input logic [4:0] op, input int unsigned a,
                                     input int unsigned b);
      res_t r;
      int unsigned x, y, s, cin, v;
      longint unsigned p;
      int sx, sy, ss;
      r = '0;
      if (op == OP_MULU) begin
         p = longint'(a) * longint'(b);
         v = int'(p & MASK);
         r.f = v[W-1:0];
         v = int'(p >> W);
         r.hi = v[W-1:0];
         r.ov = (r.hi != 0);
      end else if (op == OP_DIVU) begin
         if (b == 0) begin
            r.f = MASK[W-1:0];
            r.hi = a[W-1:0];
            r.ov = 1'b1;
         end else begin
            v = a / b;
            r.f = v[W-1:0];
            v = a % b;
            r.hi = v[W-1:0];
         end
      end else if (op == OP_RSV0 || op == OP_RSV1) begin
         r = '0;
      end else begin
         x = op[3] ? (~a & MASK) : a;
         y = op[2] ? (~b & MASK) : b;
         cin = op[2] ? 1 : 0;
         s = x + y + cin;
         sx = (x >= HALF) ? int'(x) - int'(FULL) : int'(x);
         sy = (y >= HALF) ? int'(y) - int'(FULL) : int'(y);
         ss = sx + sy + int'(cin);
         case (op[1:0])
            2'b00: begin v = x & y; r.f = v[W-1:0]; end
            2'b01: begin v = x | y; r.f = v[W-1:0]; end
            default: begin
               r.co = ((s >> W) & 1) != 0;
               r.ov = (ss < -int'(HALF)) || (ss > int'(HALF) - 1);
               if (op[1:0] == 2'b10) r.f = s[W-1:0];
               else if (op[4]) r.f = {{(W-1){1'b0}}, ~r.co};
               else r.f = {{(W-1){1'b0}}, r.ov ^ s[W-1]};
            end
         endcase
      end
      r.z = (r.f == 0);
      return r;
   endfunction

   // Cycle-level expectation: what busy/done/results must be after each edge.
   always @(posedge clk) begin
      res_t r;
      if (rst) begin
         pending = 1'b0;
         justDone = 1'b0;
         mBusy = 1'b0;
         mDone = 1'b0;
         mRes = '0;
         mRes.z = 1'b1;
      end else begin
         mDone = 1'b0;
         if (pending) begin
            remain--;
            if (remain == 0) begin
               pending = 1'b0;
               mBusy = 1'b0;
               mDone = 1'b1;
               justDone = 1'b1;
               mRes = pendRes;
            end
         end else if (justDone) begin
            justDone = 1'b0;
         end else if (bus.start) begin
            r = refModel(bus.opALU, int'(bus.A), int'(bus.B));
            if (bus.opALU == OP_MULU || bus.opALU == OP_DIVU) begin
               pending = 1'b1;
               remain = W;
               mBusy = 1'b1;
               pendRes = r;
            end else begin
               mDone = 1'b1;
               justDone = 1'b1;
               mRes = r;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chkEn) begin
         cmp("busy", 64'(bus.busy), 64'(mBusy));
         cmp("done", 64'(bus.done), 64'(mDone));
         cmp("F",    64'(bus.F),    64'(mRes.f));
         cmp("HI",   64'(bus.HI),   64'(mRes.hi));
         cmp("Z",    64'(bus.Z),    64'(mRes.z));
         cmp("CO",   64'(bus.CO),   64'(mRes.co));
         cmp("OV",   64'(bus.OV),   64'(mRes.ov));
      end
   end

   // Issue one op from idle; returns cycles until done (0 on timeout).
   task automatic doOp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.opALU = op;
      bus.A = a;
      bus.B = b;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (bus.done !== 1'b1) begin
         cmp("done_timeout", 64'(0), 64'(1));
         lat = 0;
      end
   endtask

   logic [4:0] opTab [12] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT, OP_SLTU,
                              OP_MULU, OP_DIVU, OP_RSV0, OP_RSV1, 5'b00000};

   initial begin
      int lat, busyCnt, doneCnt;
      logic [4:0] op;
      bus.start = 1'b0;
      bus.opALU = '0;
      bus.A = '0;
      bus.B = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chkEn = 1'b1;
      cmp("rst_busy", 64'(bus.busy), 64'(0));
      cmp("rst_done", 64'(bus.done), 64'(0));
      cmp("rst_F",    64'(bus.F),    64'(0));
      cmp("rst_Z",    64'(bus.Z),    64'(1));
      rst = 1'b0;

      doOp(OP_ADD, 8'h7F, 8'h01, lat);
      cmp("add_lat", 64'(lat), 64'(1));
      cmp("add_F", 64'(bus.F), 64'h80);
      cmp("add_OV", 64'(bus.OV), 64'(1));
      cmp("add_CO", 64'(bus.CO), 64'(0));
      cmp("add_Z", 64'(bus.Z), 64'(0));
      cmp("add_HI", 64'(bus.HI), 64'(0));

      doOp(OP_SUB, 8'h05, 8'h05, lat);
      cmp("sub_F", 64'(bus.F), 64'h00);
      cmp("sub_Z", 64'(bus.Z), 64'(1));
      cmp("sub_CO", 64'(bus.CO), 64'(1));
      cmp("sub_OV", 64'(bus.OV), 64'(0));

      doOp(OP_SLT, 8'h80, 8'h01, lat);
      cmp("slt_F", 64'(bus.F), 64'h01);
      doOp(OP_SLTU, 8'h80, 8'h01, lat);
      cmp("sltu_F", 64'(bus.F), 64'h00);
      doOp(OP_NOR, 8'hF0, 8'h0C, lat);
      cmp("nor_F", 64'(bus.F), 64'h03);
      doOp(OP_RSV0, 8'h5A, 8'hA5, lat);
      cmp("rsv_F", 64'(bus.F), 64'h00);
      cmp("rsv_HI", 64'(bus.HI), 64'h00);
      cmp("rsv_OV", 64'(bus.OV), 64'(0));

      // MULU with a start pulse while busy
      @(negedge clk);
      bus.start = 1'b1;
      bus.opALU = OP_MULU;
      bus.A = 8'hFF;
      bus.B = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      busyCnt = 0;
      while (bus.done !== 1'b1 && lat < 50) begin
         if (bus.busy === 1'b1) busyCnt++;
         if (lat == 3) begin
            bus.start = 1'b1;
            bus.opALU = OP_ADD;
            bus.A = 8'h11;
         end
         if (lat == 4) bus.start = 1'b0;
         @(negedge clk);
         lat++;
      end
      cmp("mul_lat", 64'(lat), 64'(W + 1));
      cmp("mul_busycycles", 64'(busyCnt), 64'(W));
      cmp("mul_F", 64'(bus.F), 64'h01);
      cmp("mul_HI", 64'(bus.HI), 64'hFE);
      cmp("mul_OV", 64'(bus.OV), 64'(1));
      cmp("mul_Z", 64'(bus.Z), 64'(0));

      doOp(OP_DIVU, 8'd200, 8'd7, lat);
      cmp("div_lat", 64'(lat), 64'(W + 1));
      cmp("div_F", 64'(bus.F), 64'h1C);
      cmp("div_HI", 64'(bus.HI), 64'h04);
      cmp("div_OV", 64'(bus.OV), 64'(0));
      doOp(OP_DIVU, 8'h35, 8'h00, lat);
      cmp("div0_F", 64'(bus.F), 64'hFF);
      cmp("div0_HI", 64'(bus.HI), 64'h35);
      cmp("div0_OV", 64'(bus.OV), 64'(1));

      // reset in the third RUN cycle of MULU, together with a start request
      @(negedge clk);
      bus.start = 1'b1;
      bus.opALU = OP_MULU;
      bus.A = 8'h12;
      bus.B = 8'h34;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1;
      bus.opALU = OP_ADD;
      @(negedge clk);
      cmp("abort_busy", 64'(bus.busy), 64'(0));
      cmp("abort_done", 64'(bus.done), 64'(0));
      cmp("abort_F", 64'(bus.F), 64'(0));
      cmp("abort_HI", 64'(bus.HI), 64'(0));
      cmp("abort_Z", 64'(bus.Z), 64'(1));
      rst = 1'b0;
      bus.start = 1'b0;
      doneCnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done === 1'b1) doneCnt++;
      end
      cmp("abort_nodone", 64'(doneCnt), 64'(0));

      // start held high with ADD: done every second cycle
      bus.start = 1'b1;
      bus.opALU = OP_ADD;
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      doneCnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done === 1'b1) doneCnt++;
         bus.A = 8'($urandom);
         bus.B = 8'($urandom);
      end
      bus.start = 1'b0;
      cmp("b2b_pulses", 64'(doneCnt), 64'(10));

      // randomized traffic, including starts while busy and occasional resets
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         op = opTab[$urandom_range(0, 11)];
         if ($urandom_range(0, 11) == 0) op = 5'($urandom);
         bus.opALU = op;
         bus.A = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
         bus.B = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         bus.start = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      repeat (W + 5) @(negedge clk);
      chkEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal range 4..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port opALU, input, 5, operation code per REQ-012/REQ-013.
REQ-006 SHALL have ports A and B, input, WIDTH each, operands captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while an iterative operation runs.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-009 SHALL have port F, output, WIDTH, primary result (product low half or quotient for MUL/DIV).
REQ-010 SHALL have port HI, output, WIDTH, product high half (MULU) or remainder (DIVU); zero for all other ops.
REQ-011 SHALL have ports Z, CO, OV, output, 1 each: zero flag, carry-out, overflow.

Function
REQ-012 SHALL decode opALU bit-fields for single-cycle ops: [1:0] selects AND/OR/ADD/SET, [3] inverts A, [2] inverts B and sets carry-in, [4] selects unsigned (1) or signed (0) SET.
REQ-013 SHALL treat opALU = 11000 as MULU and 11001 as DIVU (iterative); codes 11010, 11011 reserved, behaving as single-cycle with F=0, HI=0, flags zero.
REQ-014 SHALL implement named codes: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 01100 NOR, 00111 SLT, 10111 SLTU.
REQ-015 SHALL use an FSM with states IDLE, RUN, DONE; reset state IDLE.
REQ-016 SHALL on start=1 in IDLE capture A, B, opALU; single-cycle op -> DONE next cycle; MULU/DIVU -> RUN.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles (one iteration per cycle, counter WIDTH-1 down to 0), then go to DONE.
REQ-018 SHALL hold DONE for exactly one cycle, then return to IDLE; done=1 only in DONE, busy=1 only in RUN.
REQ-019 SHALL ignore start in RUN and DONE; start in the IDLE cycle following DONE is accepted.
REQ-020 SHALL give latency: accepted at edge k -> done=1 during cycle k+1 (single-cycle) or k+WIDTH+1 (iterative).
REQ-021 SHALL update F, HI, Z, CO, OV only on entry to DONE and hold them until the next DONE entry or reset.
REQ-022 SHALL for ADD/SUB/SLT/SLTU set CO = carry out of bit WIDTH-1 and OV = carry into MSB XOR carry out of MSB; CO=OV=0 for AND/OR/NOR.
REQ-023 SHALL set SLT result F = {0.., OV XOR sum[WIDTH-1]} and SLTU result F = {0.., ~CO}, both from A-B.
REQ-024 SHALL compute MULU by unsigned shift-add: {HI,F} = A*B (2*WIDTH bits), CO=0, OV=(HI!=0).
REQ-025 SHALL compute DIVU by restoring division: F = A/B, HI = A mod B, CO=0, OV=0.
REQ-026 SHALL on DIVU with B=0 still take WIDTH cycles and give F = all ones, HI = A, OV=1.
REQ-027 SHALL set Z = (F == 0) for every op, including MULU (HI ignored).

Reset
REQ-028 SHALL on rst=1 at an edge force IDLE, busy=0, done=0, F=0, HI=0, Z=1, CO=0, OV=0, clearing counter and internal registers.
REQ-029 SHALL let rst abort any operation in RUN or DONE with no done pulse; rst dominates a simultaneous start.

Verification
REQ-030 ADD A=0x7F B=0x01 (WIDTH=8) -> done at k+1, F=0x80, OV=1, CO=0, Z=0, HI=0.
REQ-031 SUB A=0x05 B=0x05 -> F=0x00, Z=1, CO=1, OV=0; SLT A=0x80 B=0x01 -> F=0x01; SLTU same operands -> F=0x00.
REQ-032 MULU A=0xFF B=0xFF -> busy 8 cycles, done at k+9, F=0x01, HI=0xFE, OV=1, Z=0; start pulsed during busy ignored.
REQ-033 DIVU A=200 B=7 -> F=0x1C, HI=0x04, OV=0; DIVU A=0x35 B=0 -> F=0xFF, HI=0x35, OV=1.
REQ-034 rst asserted in 3rd RUN cycle of MULU -> next cycle busy=0, done=0, F=0, HI=0, Z=1; no done pulse afterwards.
REQ-035 Back-to-back: start held high continuously with ADD -> done pulses every 2 cycles (IDLE/DONE alternation), results per latest captured operands.
